// File: rtl/wptr_full.sv
// ---------------------------------------------------------------------------
// wptr_full -- write-side pointer and status stage of the SpyBuffer async FIFO
//
// Runs entirely in the wclk domain. It keeps the binary write address and
// the Gray-coded write pointer that is sent to the read domain. From the
// already-synchronised Gray read pointer it derives registered full,
// almost-full, fill-level and sticky overflow indications.
//
// Parameters
//   ADDRSIZE   address bits; FIFO depth = 2**ADDRSIZE (>= 2)
//   AF_MARGIN  walmost_full asserts when free slots <= AF_MARGIN
//
// Ports
//   wclk          in   write-domain clock, rising edge
//   wrst_n        in   asynchronous active-low reset
//   winc          in   write request, honoured only while wfull = 0
//   wq2_rptr      in   synchronised Gray read pointer   [ADDRSIZE:0]
//   wovf_clr      in   synchronous clear of woverflow
//   waddr         out  memory write address (from wbin) [ADDRSIZE-1:0]
//   wptr          out  registered Gray write pointer     [ADDRSIZE:0]
//   wfull         out  registered full flag
//   walmost_full  out  registered almost-full flag
//   wcount        out  registered fill level 0..2**ADDRSIZE [ADDRSIZE:0]
//   woverflow     out  sticky: a write was attempted while full
// ---------------------------------------------------------------------------
module wptr_full #(
  parameter int ADDRSIZE  = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  // Fill level at or above which walmost_full asserts.
  localparam logic [PW-1:0] AF_LEVEL = PW'((1 << ADDRSIZE) - AF_MARGIN);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rbin;
  logic [PW-1:0] fill_next;
  logic [PW-1:0] full_pattern;
  logic          wen;
  logic          wfull_next;
  logic          walmost_full_next;
  logic          woverflow_next;

  // A write is accepted only if the registered full flag is low, so a
  // request arriving in the cycle full is about to drop is still refused.
  assign wen       = winc & ~wfull;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Gray-to-binary: each binary bit is the XOR of the Gray bits from
  // itself up to the MSB. Computed per bit without a ripple chain.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Full when the write pointer is exactly one lap ahead of the read
  // pointer: in Gray code that is the top two bits inverted, rest equal.
  assign full_pattern = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  // Modulo-2**PW difference; the pointers are never more than one lap
  // apart, so this lands in 0..2**ADDRSIZE.
  assign fill_next = wbinnext - rbin;

  assign wfull_next        = (wgraynext == full_pattern);
  assign walmost_full_next = (fill_next >= AF_LEVEL);

  // Set has priority over clear when both happen in the same cycle.
  assign woverflow_next = (winc & wfull) | (woverflow & ~wovf_clr);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wcount       <= fill_next;
      woverflow    <= woverflow_next;
    end
  end

  // The address for the write happening this cycle comes from the
  // current binary pointer.
  assign waddr = wbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_wptr_full -- scoreboard bench for wptr_full (ADDRSIZE=4, AF_MARGIN=2).
// The reference model counts accepted writes and the read position as plain
// integers; fill is their difference, full is fill == depth.
// ---------------------------------------------------------------------------
module tb_wptr_full;

  localparam int AS    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 2;

  logic          wclk     = 1'b0;
  logic          wrst_n   = 1'b1;
  logic          winc     = 1'b0;
  logic [AS:0]   wq2_rptr = '0;
  logic          wovf_clr = 1'b0;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AS:0]   wcount;
  logic          woverflow;

  wptr_full #(.ADDRSIZE(AS), .AF_MARGIN(AF)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [AS-1:0] waddr;
    logic [AS:0]   wptr;
    logic          full;
    logic          af;
    logic [AS:0]   cnt;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_writes = 0;
  int m_rd     = 0;
  bit m_full   = 0;
  bit m_ovf    = 0;

  function automatic logic [AS:0] to_gray(input int n);
    logic [AS:0] b;
    b = (AS+1)'(n % (2*DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the expected post-edge outputs.
  task automatic step(input bit inc, input bit clr, input int rd);
    exp_t e;
    int   cnt;
    @(negedge wclk);
    winc     = inc;
    wovf_clr = clr;
    m_rd     = rd;
    wq2_rptr = to_gray(rd);
    if (!wrst_n) begin
      m_writes = 0;
      m_full   = 0;
      m_ovf    = 0;
      e.waddr = '0; e.wptr = '0; e.full = 0; e.af = 0; e.cnt = '0; e.ovf = 0;
    end else begin
      if (inc && m_full)  m_ovf = 1;
      else if (clr)       m_ovf = 0;
      if (inc && !m_full) m_writes++;
      cnt     = m_writes - rd;
      m_full  = (cnt == DEPTH);
      e.waddr = AS'(m_writes % DEPTH);
      e.wptr  = to_gray(m_writes);
      e.full  = m_full;
      e.af    = (cnt >= DEPTH - AF);
      e.cnt   = (AS+1)'(cnt);
      e.ovf   = m_ovf;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: compare each edge's outputs against the queued expectation and
  // check that wptr moves by at most one bit per clock.
  initial begin
    logic [AS:0] prev;
    bit          pv;
    exp_t        e;
    pv   = 0;
    prev = '0;
    forever begin
      @(posedge wclk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (waddr        !== e.waddr) chk("waddr",        int'(waddr),        int'(e.waddr));
        else                          chk("waddr",        int'(waddr),        int'(e.waddr));
        chk("wptr",         int'(wptr),         int'(e.wptr));
        chk("wfull",        int'(wfull),        int'(e.full));
        chk("walmost_full", int'(walmost_full), int'(e.af));
        chk("wcount",       int'(wcount),       int'(e.cnt));
        chk("woverflow",    int'(woverflow),    int'(e.ovf));
      end
      if (wrst_n && pv) begin
        chk("wptr_bits_changed_le1", ($countones(wptr ^ prev) <= 1) ? 1 : 0, 1);
      end
      pv   = wrst_n;
      prev = wptr;
    end
  end

  initial begin
    int w1, w2, start, steps, rd;
    bit inc;

    // Reset held with winc toggling
    #1 wrst_n = 1'b0;
    for (int i = 0; i < 4; i++) step(i % 2 == 1, 0, 0);
    @(posedge wclk); #2;
    wrst_n = 1'b1;
    chk("waddr_after_release", int'(waddr), 0);

    // Fill from empty with the read pointer parked at 0
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);

    // Overflow: blocked writes, clear, set-wins-over-clear
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);

    // Drain release: reader at 4, then refill
    step(0, 0, 4);
    for (int i = 0; i < 4; i++) step(1, 0, 4);

    // Wrap: reader trails the writer by two cycles
    w1 = m_writes; w2 = m_writes;
    start = m_writes; steps = 0;
    while ((m_writes - start) < 100 && steps < 400) begin
      inc = ($urandom_range(0, 3) != 0);
      step(inc, 0, w2);
      w2 = w1;
      w1 = m_writes;
      steps++;
    end
    chk("wrap_100_writes_done", ((m_writes - start) >= 100) ? 1 : 0, 1);

    // Randomized traffic: slow reader so full and overflow occur
    rd = m_rd;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0 && rd < m_writes) rd++;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, rd);
    end

    // Asynchronous reset in the middle of a fill
    @(posedge wclk); #2;
    wrst_n = 1'b0;
    step(0, 0, 0);
    step(1, 0, 0);
    @(posedge wclk); #2;
    wrst_n = 1'b1;
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    @(posedge wclk); #3;
    chk("wcount_before_async_reset", int'(wcount), 9);
    wrst_n = 1'b0;
    #1;
    chk("async_rst_wptr",         int'(wptr),         0);
    chk("async_rst_waddr",        int'(waddr),        0);
    chk("async_rst_wcount",       int'(wcount),       0);
    chk("async_rst_wfull",        int'(wfull),        0);
    chk("async_rst_walmost_full", int'(walmost_full), 0);
    chk("async_rst_woverflow",    int'(woverflow),    0);
    step(1, 0, 0);
    @(posedge wclk); #2;
    wrst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0);

    @(posedge wclk); #3;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
